cordic_lin_div: RTL and testbench

- Iterative linear-mode (vectoring) CORDIC divider sitting directly downstream of the hyperbolic CORDIC activation stage.
- Consumes that stage's hyperbolic outputs, num = yn (sinh) and den = xn (cosh), and produces quo = num/den.
- In this use the quotient is tanh(z), handed to the activation output mux.
- Signed Q3.5 fixed point, the same format as the upstream stage. Single outstanding operation with valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_lin_iter.sv | 38 +++
 rtl/cordic_lin_div.sv | 162 ++++++++++++++++
 tb/tb_cordic_lin_div.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC activation datapath: fixed-point format,
// linear-divider FSM states and the divider result record.
package cordic_pkg;

    localparam int CORDIC_W    = 8;
    localparam int CORDIC_FRAC = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lin_state_e;

    typedef struct packed {
        logic [CORDIC_W-1:0] quo;
        logic                div_err;
    } lin_res_t;

endpackage

// File: rtl/cordic_lin_iter.sv
// One linear-mode vectoring CORDIC step: drive y towards zero by +/- x/2^i
// and accumulate the matching +/- 2^-i into the quotient z.
module cordic_lin_iter #(
    parameter int EW   = 16,
    parameter int ZW   = 8,
    parameter int FRAC = 5,
    parameter int IW   = 3
) (
    input  logic signed [EW-1:0] i_y,
    input  logic signed [EW-1:0] i_x,
    input  logic signed [ZW-1:0] i_z,
    input  logic        [IW-1:0] i_i,
    output logic signed [EW-1:0] o_y,
    output logic signed [ZW-1:0] o_z
);

    localparam logic signed [ZW-1:0] ONE = ZW'(1);

    logic signed [EW-1:0] w_x_sh;
    logic signed [ZW-1:0] w_step;

    // Single iteration; y==0 holds y and z so exact quotients stay exact.
    always_comb begin
        w_x_sh = i_x >>> i_i;
        w_step = ONE <<< (IW'(FRAC) - i_i);
        if (i_y == '0) begin
            o_y = i_y;
            o_z = i_z;
        end else if (i_y[EW-1]) begin
            o_y = i_y + w_x_sh;
            o_z = i_z - w_step;
        end else begin
            o_y = i_y - w_x_sh;
            o_z = i_z + w_step;
        end
    end

endmodule

// File: rtl/cordic_lin_div.sv
// Iterative linear-mode CORDIC divider: quo = num/den in signed Q3.5, used to
// form tanh = sinh/cosh from the hyperbolic stage outputs.
module cordic_lin_div
    import cordic_pkg::*;
#(
    parameter int W    = CORDIC_W,
    parameter int FRAC = CORDIC_FRAC,
    parameter int ITER = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quo,
    output logic         div_err
);

    localparam int EW = W + ITER + 2;
    localparam int ZW = FRAC + 3;
    localparam int CW = $clog2(FRAC + 2);
    localparam logic [CW-1:0]       LAST    = CW'(ITER - 1);
    localparam logic signed [W-1:0] SAT_POS = W'((1 << (FRAC + 1)) - 1);
    localparam logic signed [W-1:0] SAT_NEG = W'(-((1 << (FRAC + 1)) - 1));

    lin_state_e           r_state;
    lin_state_e           w_next;
    logic signed [EW-1:0] r_y;
    logic signed [EW-1:0] r_x;
    logic signed [ZW-1:0] r_z;
    logic        [CW-1:0] r_cnt;
    lin_res_t             r_res;
    logic                 r_out_valid;

    logic signed [EW-1:0] w_y_nxt;
    logic signed [ZW-1:0] w_z_nxt;
    logic signed [W+1:0]  w_num_ext;
    logic signed [W+1:0]  w_abs_num;
    logic signed [W+1:0]  w_twice_den;
    logic                 w_den_bad;
    logic                 w_range_bad;
    logic                 w_accept;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign quo       = r_res.quo;
    assign div_err   = r_res.div_err;

    // Operand screening: non-positive divisor, or |q| >= 2 which cannot converge.
    always_comb begin
        w_num_ext   = {{2{num[W-1]}}, num};
        w_twice_den = {den[W-1], den, 1'b0};
        if (num[W-1]) begin
            w_abs_num = -w_num_ext;
        end else begin
            w_abs_num = w_num_ext;
        end
        w_den_bad   = den[W-1] || (den == '0);
        w_range_bad = (w_abs_num >= w_twice_den);
    end

    cordic_lin_iter #(
        .EW   (EW),
        .ZW   (ZW),
        .FRAC (FRAC),
        .IW   (CW)
    ) u_iter (
        .i_y (r_y),
        .i_x (r_x),
        .i_z (r_z),
        .i_i (r_cnt),
        .o_y (w_y_nxt),
        .o_z (w_z_nxt)
    );

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_den_bad || w_range_bad) begin
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; out_valid is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == DONE);
        end
    end

    // Datapath: load on accept, iterate in RUN, latch the result record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_x   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_den_bad) begin
                            r_res <= '{quo: '0, div_err: 1'b1};
                        end else if (w_range_bad) begin
                            r_res <= '{quo: (($signed(num) > 0) ? SAT_POS : SAT_NEG),
                                       div_err: 1'b1};
                        end else begin
                            r_y   <= EW'($signed(num)) <<< ITER;
                            r_x   <= EW'($signed(den)) <<< ITER;
                            r_z   <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    r_y   <= w_y_nxt;
                    r_z   <= w_z_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_res <= '{quo: W'(w_z_nxt), div_err: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_lin_div.sv
// Scoreboard bench for cordic_lin_div: expectations are queued at the accepting
// edge and compared when the DUT hands a result over.
module tb_cordic_lin_div;

    localparam int ITER = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] num = 8'h00;
    logic [7:0] den = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       div_err;
    logic [7:0] quo;

    typedef struct {
        int q;
        int e;
        int tol;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   hyp_shift[6] = '{1, 2, 3, 4, 4, 5};
    int   hyp_atanh[6] = '{18, 8, 4, 2, 2, 1};

    always #5 clk = ~clk;

    cordic_lin_div #(.ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .div_err   (div_err)
    );

    // Passes when exp <= obs <= exp + tol.
    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        checks++;
        if (obs < exp || obs > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, obs, exp, exp + tol);
        end
    endtask

    // Reference divider: error classes, else floor of the real quotient (+1 LSB if inexact).
    function automatic exp_t model(input logic [7:0] n, input logic [7:0] d);
        exp_t r;
        int ni, di, p, q;
        ni = int'($signed(n));
        di = int'($signed(d));
        r.tol = 0;
        if (di <= 0) begin
            r.q = 0;
            r.e = 1;
        end else if ((ni < 0 ? -ni : ni) >= 2 * di) begin
            r.q = (ni > 0) ? 63 : -63;
            r.e = 1;
        end else begin
            r.e = 0;
            p = ni * 32;
            q = p / di;
            if (p % di != 0) begin
                r.tol = 1;
                if (p < 0) q = q - 1;
            end
            r.q = q;
        end
        return r;
    endfunction

    // Upstream hyperbolic CORDIC (rotation mode, iteration 4 repeated) in Q3.5.
    task automatic hyp_cordic(input int x0, input int y0, input int z0, output int xn, output int yn);
        int x, y, z, xt;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < 6; k++) begin
            xt = x;
            if (z >= 0) begin
                x = x + (y >>> hyp_shift[k]);
                y = y + (xt >>> hyp_shift[k]);
                z = z - hyp_atanh[k];
            end else begin
                x = x - (y >>> hyp_shift[k]);
                y = y - (xt >>> hyp_shift[k]);
                z = z + hyp_atanh[k];
            end
        end
        xn = x;
        yn = y;
    endtask

    task automatic accept(input logic [7:0] n, input logic [7:0] d);
        int k;
        @(negedge clk);
        num = n; den = d; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait", int'(in_ready), 1);
        @(posedge clk);
        sb.push_back(model(n, d));
        #1;
        in_valid = 1'b0; num = 8'h55; den = 8'h00;
    endtask

    task automatic send(input logic [7:0] n, input logic [7:0] d, input int exp_lat);
        int cnt;
        accept(n, d);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", cnt, exp_lat);
    endtask

    // Result monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", int'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                check("quo", int'($signed(quo)), mon_e.q, mon_e.tol);
                check("div_err", int'(div_err), mon_e.e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xn, yn, d, lim, lo, hi, n, cnt;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quo", int'(quo), 0);
        check("rst_div_err", int'(div_err), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(8'h10, 8'h20, ITER);
        send(8'h0C, 8'h20, ITER);
        send(8'hF0, 8'h20, ITER);
        send(8'h08, 8'h18, ITER);

        send(8'h00, 8'h00, 0);
        send(8'h10, 8'hE0, 0);
        send(8'h40, 8'h20, 0);
        send(8'hC0, 8'h20, 0);

        // Backpressure: result held while out_ready is low, then handoff.
        @(posedge clk); #1 out_ready = 1'b0;
        send(8'h0C, 8'h20, ITER);
        @(negedge clk);
        num = 8'h10; den = 8'h20; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_quo", int'($signed(quo)), 12);
            check("bp_err", int'(div_err), 0);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("handoff_valid", int'(out_valid), 0);
        check("handoff_in_ready", int'(in_ready), 1);
        @(posedge clk);
        sb.push_back(model(8'h10, 8'h20));
        #1 in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("b2b_latency", cnt, ITER);

        // Reset in the middle of RUN after an error result left quo/div_err set.
        send(8'h40, 8'h20, 0);
        accept(8'h10, 8'h20);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_quo", int'(quo), 0);
        check("mid_rst_err", int'(div_err), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        send(8'h0C, 8'h20, ITER);

        // tanh(0.5) from the upstream hyperbolic stage.
        hyp_cordic(32'sh26, 0, 32'sh10, xn, yn);
        send(8'(yn), 8'(xn), ITER);
        check("tanh", int'($signed(quo)), 14, 2);

        for (int k = 0; k < 40; k++) begin
            d   = int'($urandom_range(1, 127));
            lim = 2 * d - 1;
            lo  = (lim > 128) ? -128 : -lim;
            hi  = (lim > 127) ? 127 : lim;
            n   = lo + int'($urandom_range(0, hi - lo));
            send(8'(n), 8'(d), ITER);
        end

        repeat (4) @(negedge clk);
        check("sb_drain", int'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
